ram_prog_loader: RTL and testbench

//  Serial front-end for the RAM programming port of the 8-bit computer. Receives
//  a 16-byte program image over a slow 2-wire serial link (ser_clk/ser_data,
//  MSB first) and drives prog_mode/addr/data_in so that each received byte is

---
 rtl/ram_prog_loader.sv | 248 ++++++++++++++++++++++++
 tb/tb_ram_prog_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_prog_loader.sv
// ram_prog_loader
//   Serial front-end for the RAM programming port of the 8-bit computer.
//   A program image of NUM_WORDS bytes arrives over a slow two-wire link.
//   ser_clk is the serial clock and ser_data is the data line, sent MSB first.
//   Each byte is presented on addr/data_in with a one-cycle prog_we strobe.
//   prog_mode is held high while a load is in progress.
//
// Ports
//   fastClk   in   system clock; all state changes on its rising edge
//   rst       in   synchronous, active-high reset
//   start     in   level; begins a load when idle, done or in error
//   abort     in   level; returns to idle from any state, flags untouched
//   ser_clk   in   asynchronous serial clock; data sampled on its rise
//   ser_data  in   asynchronous serial data, MSB first
//   prog_mode out  high while a load is in progress
//   addr      out  RAM program address of the last committed word
//   data_in   out  RAM program data of the last committed word
//   prog_we   out  one-cycle strobe when addr/data_in take a new word
//   done      out  sticky: complete image loaded
//   error     out  sticky: serial clock stalled in the middle of a byte
module ram_prog_loader #(
  parameter int NUM_WORDS      = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic          fastClk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          ser_clk,
  input  logic          ser_data,
  output logic          prog_mode,
  output logic [AW-1:0] addr,
  output logic [7:0]    data_in,
  output logic          prog_we,
  output logic          done,
  output logic          error
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_WORDS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT,
    S_DONE,
    S_ERROR
  } state_t;

  // ---------------------------------------------------------------
  // Input synchronisers. Stage gi samples stage gi-1, and stage 0
  // samples the pin. The data line uses the same depth as the clock
  // line, so the sampled bit stays aligned with the detected rise.
  // ---------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic clk_q_reg;
      logic data_q_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge fastClk) begin
          if (rst) begin
            clk_q_reg  <= 1'b0;
            data_q_reg <= 1'b0;
          end else begin
            clk_q_reg  <= ser_clk;
            data_q_reg <= ser_data;
          end
        end
      end else begin : g_next
        always_ff @(posedge fastClk) begin
          if (rst) begin
            clk_q_reg  <= 1'b0;
            data_q_reg <= 1'b0;
          end else begin
            clk_q_reg  <= g_sync[gi-1].clk_q_reg;
            data_q_reg <= g_sync[gi-1].data_q_reg;
          end
        end
      end
    end
  endgenerate

  logic sclk_sync;
  logic sdata_sync;
  logic sclk_prev_reg;
  logic rise;

  assign sclk_sync  = g_sync[SYNC_STAGES-1].clk_q_reg;
  assign sdata_sync = g_sync[SYNC_STAGES-1].data_q_reg;
  assign rise       = sclk_sync & ~sclk_prev_reg;

  always_ff @(posedge fastClk) begin
    if (rst) sclk_prev_reg <= 1'b0;
    else     sclk_prev_reg <= sclk_sync;
  end

  // ---------------------------------------------------------------
  // Control state
  // The shift register keeps only the 7 most recent bits. The 8th bit
  // is taken directly from the synchroniser when the word is committed.
  // ---------------------------------------------------------------
  state_t          state_reg,     state_next;
  logic [6:0]      shreg_reg,     shreg_next;
  logic [2:0]      bit_cnt_reg,   bit_cnt_next;
  logic [AW-1:0]   word_idx_reg,  word_idx_next;
  logic [TW-1:0]   to_cnt_reg,    to_cnt_next;
  logic [AW-1:0]   addr_reg,      addr_next;
  logic [7:0]      data_reg,      data_next;
  logic            we_reg,        we_next;
  logic            mode_reg,      mode_next;
  logic            done_reg,      done_next;
  logic            error_reg,     error_next;

  always_ff @(posedge fastClk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      shreg_reg    <= '0;
      bit_cnt_reg  <= '0;
      word_idx_reg <= '0;
      to_cnt_reg   <= '0;
      addr_reg     <= '0;
      data_reg     <= '0;
      we_reg       <= 1'b0;
      mode_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shreg_reg    <= shreg_next;
      bit_cnt_reg  <= bit_cnt_next;
      word_idx_reg <= word_idx_next;
      to_cnt_reg   <= to_cnt_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
      we_reg       <= we_next;
      mode_reg     <= mode_next;
      done_reg     <= done_next;
      error_reg    <= error_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    shreg_next    = shreg_reg;
    bit_cnt_next  = bit_cnt_reg;
    word_idx_next = word_idx_reg;
    to_cnt_next   = to_cnt_reg;
    addr_next     = addr_reg;
    data_next     = data_reg;
    we_next       = 1'b0;
    mode_next     = mode_reg;
    done_next     = done_reg;
    error_next    = error_reg;

    case (state_reg)
      S_IDLE, S_DONE, S_ERROR: begin
        // Serial edges are ignored here; only start matters.
        if (start) begin
          state_next    = S_LOAD;
          mode_next     = 1'b1;
          done_next     = 1'b0;
          error_next    = 1'b0;
          bit_cnt_next  = '0;
          word_idx_next = '0;
          to_cnt_next   = '0;
        end
      end

      S_LOAD: begin
        if (rise) begin
          shreg_next   = {shreg_reg[5:0], sdata_sync};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          to_cnt_next  = '0;
          if (bit_cnt_reg == 3'd7) begin
            // addr and data_in move together on the edge that enters
            // COMMIT. prog_we is high for the COMMIT cycle, so the
            // strobe coincides exactly with the new word.
            state_next = S_COMMIT;
            addr_next  = word_idx_reg;
            data_next  = {shreg_reg, sdata_sync};
            we_next    = 1'b1;
          end
        end else if (bit_cnt_reg != 3'd0) begin
          if (to_cnt_reg == TO_LAST) begin
            state_next   = S_ERROR;
            mode_next    = 1'b0;
            error_next   = 1'b1;
            bit_cnt_next = '0;
            to_cnt_next  = '0;
          end else begin
            to_cnt_next = to_cnt_reg + 1'b1;
          end
        end else begin
          // The gap between bytes is allowed to be arbitrarily long.
          to_cnt_next = '0;
        end
      end

      S_COMMIT: begin
        word_idx_next = word_idx_reg + 1'b1;
        if (word_idx_reg == LAST_IDX) begin
          state_next = S_DONE;
          mode_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          state_next = S_LOAD;
          // Do not drop a fast sender's first bit of the next byte.
          if (rise) begin
            shreg_next   = {shreg_reg[5:0], sdata_sync};
            bit_cnt_next = 3'd1;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
        mode_next  = 1'b0;
      end
    endcase

    // Abort overrides everything, including a start in the same cycle
    // and a commit that would otherwise land on this edge.
    if (abort) begin
      state_next    = S_IDLE;
      mode_next     = 1'b0;
      we_next       = 1'b0;
      addr_next     = addr_reg;
      data_next     = data_reg;
      done_next     = done_reg;
      error_next    = error_reg;
      word_idx_next = word_idx_reg;
      bit_cnt_next  = '0;
      to_cnt_next   = '0;
    end
  end

  assign prog_mode = mode_reg;
  assign addr      = addr_reg;
  assign data_in   = data_reg;
  assign prog_we   = we_reg;
  assign done      = done_reg;
  assign error     = error_reg;

endmodule

// File: tb/tb_ram_prog_loader.sv
// tb_ram_prog_loader
//   Self-checking bench for ram_prog_loader. Random image bytes are sent over
//   the serial pins. Every prog_we strobe is recorded by a monitor. The record
//   is compared against the image that the bench itself chose.
module tb_ram_prog_loader;

  localparam int NW = 16;
  localparam int TO = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       ser_clk = 1'b0;
  logic       ser_data = 1'b0;
  logic       prog_mode;
  logic [3:0] addr;
  logic [7:0] data_in;
  logic       prog_we;
  logic       done;
  logic       error;

  ram_prog_loader #(
    .NUM_WORDS(NW),
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .fastClk  (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .ser_clk  (ser_clk),
    .ser_data (ser_data),
    .prog_mode(prog_mode),
    .addr     (addr),
    .data_in  (data_in),
    .prog_we  (prog_we),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Write monitor. It samples on the falling edge. It logs every strobe,
  // strobes longer than one cycle, and any addr/data change made without
  // a strobe.
  logic [3:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int         we_wide  = 0;
  int         spurious = 0;
  logic       we_prev  = 1'b0;
  logic [3:0] addr_prev = '0;
  logic [7:0] data_prev = '0;

  always @(negedge clk) begin
    if (prog_we === 1'b1) begin
      wr_addr_q.push_back(addr);
      wr_data_q.push_back(data_in);
      if (we_prev === 1'b1) we_wide++;
    end
    if (!rst && prog_we !== 1'b1 && (addr !== addr_prev || data_in !== data_prev))
      spurious++;
    we_prev   = prog_we;
    addr_prev = addr;
    data_prev = data_in;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    $display("check %-18s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance n clock cycles, then stop just after the rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ser_data = b;
    step($urandom_range(4, 7));
    ser_clk = 1'b1;
    step($urandom_range(4, 7));
    ser_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Compare the monitor's log against the model: word i, written at
  // address i, for the first n words of the image.
  task automatic check_image(input string tag, input logic [7:0] img[NW], input int n);
    check({tag, "_count"}, wr_addr_q.size(), n);
    for (int i = 0; i < n && i < wr_addr_q.size(); i++)
      check({tag, "_word"}, {wr_addr_q[i], wr_data_q[i]}, {i[3:0], img[i]});
  endtask

  logic [7:0] img[NW];
  int         cyc;
  int         sz;

  initial begin
    // Reset state
    step(3);
    @(negedge clk);
    check("rst_outputs", {prog_mode, addr, data_in, prog_we, done, error}, 32'h0);
    step(1);
    rst = 1'b0;
    step(2);

    // Full load. Byte 0 is the directed 0xA5; the others are random.
    img[0] = 8'hA5;
    for (int i = 1; i < NW; i++) img[i] = 8'($urandom);
    clear_log();
    pulse_start();
    check("load_mode_on", {prog_mode, done, error}, 3'b100);
    for (int i = 0; i < NW; i++) send_byte(img[i]);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin step(1); cyc++; end
    @(negedge clk);
    check("load_end_flags", {prog_mode, done, error}, 3'b010);
    check_image("load1", img, NW);
    check("hold_after_load", {addr, data_in}, {4'(NW - 1), img[NW-1]});

    // Serial activity in DONE must not write anything.
    sz = wr_addr_q.size();
    send_byte(8'($urandom));
    step(5);
    check("done_ignore_wr", wr_addr_q.size(), sz);
    check("done_ignore_hold", {done, prog_mode, addr, data_in}, {2'b10, 4'(NW - 1), img[NW-1]});

    // Stall after 3 bits: the timeout must fire.
    clear_log();
    pulse_start();
    check("restart_clr_done", {prog_mode, done, error}, 3'b100);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    cyc = 0;
    while (error !== 1'b1 && cyc < 5000) begin step(1); cyc++; end
    @(negedge clk);
    check("timeout_flags", {prog_mode, done, error}, 3'b001);
    check("timeout_window", (cyc >= TO - 16 && cyc <= TO + 4), 1);
    check("timeout_no_wr", wr_addr_q.size(), 0);

    // A restart clears error, and a full reload succeeds from address 0.
    for (int i = 0; i < NW; i++) img[i] = 8'($urandom);
    step(1);
    pulse_start();
    check("restart_clr_err", {prog_mode, done, error}, 3'b100);
    for (int i = 0; i < NW; i++) send_byte(img[i]);
    step(5);
    @(negedge clk);
    check("reload_flags", {prog_mode, done, error}, 3'b010);
    check_image("load2", img, NW);

    // Abort during the sixth byte. The five completed words stay, and
    // addr holds the last one.
    for (int i = 0; i < NW; i++) img[i] = 8'($urandom);
    step(1);
    clear_log();
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(img[i]);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    @(negedge clk);
    check("abort_flags", {prog_mode, done, error}, 3'b000);
    check("abort_hold", {addr, data_in}, {4'd4, img[4]});
    for (int i = 0; i < 13; i++) send_bit(1'($urandom));
    step(5);
    check_image("abort", img, 5);

    // When abort and start are both high, abort wins.
    start = 1'b1;
    abort = 1'b1;
    step(1);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("abort_beats_start", prog_mode, 1'b0);

    // Reset in the middle of a byte.
    step(1);
    clear_log();
    pulse_start();
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    sz = wr_addr_q.size();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_outputs", {prog_mode, addr, data_in, prog_we, done, error}, 32'h0);
    check("midrst_no_wr", wr_addr_q.size(), sz);
    step(1);
    rst = 1'b0;
    step(2);

    // Serial activity in IDLE must not write anything.
    clear_log();
    send_byte(8'($urandom));
    step(5);
    @(negedge clk);
    check("idle_ignore_wr", wr_addr_q.size(), 0);
    check("idle_ignore_hold", {prog_mode, addr, data_in}, 13'h0);

    // Properties accumulated by the monitor over the whole run.
    check("we_one_cycle", we_wide, 0);
    check("addr_data_moves", spurious, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
